iitk_mini_mips: RTL and testbench

Single-cycle, word-addressed 32-bit MIPS-style processor core: PC, instruction memory, 32×32 register file, ALU, data memory and a one-hot-ish decode flag set. It is the top-level compute block of the Mini-MIPS design. Memories are internal arrays loaded hierarchically by the bench. No external bus.

---
 rtl/iitk_mips_pkg.sv | 63 ++++++
 rtl/iitk_mips_alu.sv | 29 ++
 rtl/iitk_mini_mips.sv | 202 ++++++++++++++++++++
 tb/tb_iitk_mini_mips.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/iitk_mips_pkg.sv
// Shared opcodes, funct codes, ALU operations and decoded-control record for the Mini-MIPS core.
// Optional JAL support is enabled by defining IITK_MIPS_JAL_EN.
package iitk_mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLA   = 6'b010100;
   localparam logic [5:0] OP_SRA   = 6'b010101;
   localparam logic [5:0] OP_LW    = 6'b011101;
   localparam logic [5:0] OP_SW    = 6'b011110;
   localparam logic [5:0] OP_BEQ   = 6'b010000;
   localparam logic [5:0] OP_BNE   = 6'b010001;
   localparam logic [5:0] OP_J     = 6'b011000;
   localparam logic [5:0] OP_JAL   = 6'b011001;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_XOR = 6'h26;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRA
   } alu_op_e;

   typedef enum logic [1:0] {WSEL_ALU, WSEL_MEM, WSEL_LINK} wsel_e;
   typedef enum logic [1:0] {BSEL_RT, BSEL_SEXT, BSEL_ZEXT} bsel_e;
   typedef enum logic [1:0] {DST_RD, DST_RT, DST_R31} dst_e;

   typedef struct packed {
      logic    alu;
      logic    mem;
      logic    branch;
      logic    jump;
      logic    r_type;
      logic    i_type;
      logic    j_type;
      logic    reg_we;
      logic    mem_we;
      logic    br_ne;
      wsel_e   wsel;
      bsel_e   bsel;
      dst_e    dst;
      alu_op_e alu_op;
   } ctrl_t;

   // Euclidean modulo so negative branch offsets wrap back into the memory.
   function automatic logic [31:0] wrap_index(input logic signed [33:0] v,
                                              input logic signed [33:0] depth);
      logic signed [33:0] r;
      r = v % depth;
      if (r < 34'sd0) begin
         r = r + depth;
      end else begin
         r = r;
      end
      return r[31:0];
   endfunction

endpackage

// File: rtl/iitk_mips_alu.sv
// Combinational 32-bit ALU of the Mini-MIPS core; zero flag drives BEQ/BNE.
module iitk_mips_alu
   import iitk_mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  alu_op_e     alu_op,
   output logic [31:0] result,
   output logic        zero
);

   // Operation select; shifts use only the low five bits of b.
   always_comb begin
      result = 32'd0;
      case (alu_op)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
         ALU_SLL: result = a << b[4:0];
         ALU_SRA: result = $unsigned($signed(a) >>> b[4:0]);
         default: result = 32'd0;
      endcase
      zero = (result == 32'd0);
   end

endmodule

// File: rtl/iitk_mini_mips.sv
// Single-cycle word-addressed Mini-MIPS core: PC, memories, register file and decoder.
// Define IITK_MIPS_JAL_EN to decode JAL (opcode 011001); otherwise it executes as a NOP.
module iitk_mini_mips
   import iitk_mips_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
)(
   input logic clk,
   input logic reset
);

   localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int DW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
   localparam logic signed [33:0] IDEPTH = 34'(IMEM_DEPTH);
   localparam logic signed [33:0] DDEPTH = 34'(DMEM_DEPTH);

   logic [31:0]   instruction_memory [0:IMEM_DEPTH-1];
   logic [31:0]   data_memory [0:DMEM_DEPTH-1];
   logic [31:0]   register_file [0:31];
   logic [IW-1:0] pc;
   logic [IW-1:0] pc_d;
   logic [31:0]   instruction;
   logic          alu, mem, branch, jump, R, I, J;

   ctrl_t       ctrl_s;
   logic [5:0]  opcode_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s;
   logic [15:0] imm_s;
   logic [25:0] target_s;
   logic [31:0] rs_val_s, rt_val_s, alu_b_s, alu_res_s;
   logic        alu_zero_s;
   logic [31:0] pc_inc_idx_s, pc_br_idx_s, pc_j_idx_s, dmem_idx_s;
   logic [DW-1:0] dmem_addr_s;
   logic [4:0]  rf_waddr_s;
   logic [31:0] rf_wdata_s;
   logic        rf_we_s;
   logic        unused_ok_s;

   assign instruction = instruction_memory[pc];
   assign opcode_s    = instruction[31:26];
   assign rs_s        = instruction[25:21];
   assign rt_s        = instruction[20:16];
   assign rd_s        = instruction[15:11];
   assign funct_s     = instruction[5:0];
   assign imm_s       = instruction[15:0];
   assign target_s    = instruction[25:0];

   assign rs_val_s = (rs_s == 5'd0) ? 32'd0 : register_file[rs_s];
   assign rt_val_s = (rt_s == 5'd0) ? 32'd0 : register_file[rt_s];

   // Decoder: unknown opcodes stay all-zero; unknown funct keeps only the R flag.
   always_comb begin
      ctrl_s        = '0;
      ctrl_s.alu_op = ALU_ADD;
      case (opcode_s)
         OP_RTYPE: begin
            ctrl_s.r_type = 1'b1;
            ctrl_s.dst    = DST_RD;
            ctrl_s.alu    = 1'b1;
            case (funct_s)
               F_ADD:   ctrl_s.alu_op = ALU_ADD;
               F_SUB:   ctrl_s.alu_op = ALU_SUB;
               F_AND:   ctrl_s.alu_op = ALU_AND;
               F_OR:    ctrl_s.alu_op = ALU_OR;
               F_XOR:   ctrl_s.alu_op = ALU_XOR;
               F_SLT:   ctrl_s.alu_op = ALU_SLT;
               default: ctrl_s.alu    = 1'b0;
            endcase
            ctrl_s.reg_we = ctrl_s.alu;
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLA, OP_SRA: begin
            ctrl_s.i_type = 1'b1;
            ctrl_s.alu    = 1'b1;
            ctrl_s.reg_we = 1'b1;
            ctrl_s.dst    = DST_RT;
            ctrl_s.bsel   = BSEL_SEXT;
            case (opcode_s)
               OP_ANDI: begin ctrl_s.alu_op = ALU_AND; ctrl_s.bsel = BSEL_ZEXT; end
               OP_ORI:  begin ctrl_s.alu_op = ALU_OR;  ctrl_s.bsel = BSEL_ZEXT; end
               OP_SLA:  ctrl_s.alu_op = ALU_SLL;
               OP_SRA:  ctrl_s.alu_op = ALU_SRA;
               default: ctrl_s.alu_op = ALU_ADD;
            endcase
         end
         OP_LW, OP_SW: begin
            ctrl_s.i_type = 1'b1;
            ctrl_s.mem    = 1'b1;
            ctrl_s.bsel   = BSEL_SEXT;
            ctrl_s.dst    = DST_RT;
            ctrl_s.wsel   = WSEL_MEM;
            ctrl_s.reg_we = (opcode_s == OP_LW);
            ctrl_s.mem_we = (opcode_s == OP_SW);
         end
         OP_BEQ, OP_BNE: begin
            ctrl_s.i_type = 1'b1;
            ctrl_s.branch = 1'b1;
            ctrl_s.alu_op = ALU_SUB;
            ctrl_s.br_ne  = (opcode_s == OP_BNE);
         end
         OP_J: begin
            ctrl_s.j_type = 1'b1;
            ctrl_s.jump   = 1'b1;
         end
`ifdef IITK_MIPS_JAL_EN
         OP_JAL: begin
            ctrl_s.j_type = 1'b1;
            ctrl_s.jump   = 1'b1;
            ctrl_s.reg_we = 1'b1;
            ctrl_s.dst    = DST_R31;
            ctrl_s.wsel   = WSEL_LINK;
         end
`endif
         default: ctrl_s = '0;
      endcase
   end

   assign alu    = ctrl_s.alu;
   assign mem    = ctrl_s.mem;
   assign branch = ctrl_s.branch;
   assign jump   = ctrl_s.jump;
   assign R      = ctrl_s.r_type;
   assign I      = ctrl_s.i_type;
   assign J      = ctrl_s.j_type;

   // ALU second operand select.
   always_comb begin
      case (ctrl_s.bsel)
         BSEL_RT:   alu_b_s = rt_val_s;
         BSEL_SEXT: alu_b_s = {{16{imm_s[15]}}, imm_s};
         BSEL_ZEXT: alu_b_s = {16'd0, imm_s};
         default:   alu_b_s = rt_val_s;
      endcase
   end

   iitk_mips_alu u_alu (
      .a      (rs_val_s),
      .b      (alu_b_s),
      .alu_op (ctrl_s.alu_op),
      .result (alu_res_s),
      .zero   (alu_zero_s)
   );

   assign pc_inc_idx_s = wrap_index(34'(pc) + 34'd1, IDEPTH);
   assign pc_br_idx_s  = wrap_index(34'(pc) + 34'd1 + {{18{imm_s[15]}}, imm_s}, IDEPTH);
   assign pc_j_idx_s   = wrap_index({8'd0, target_s}, IDEPTH);
   assign dmem_idx_s   = wrap_index({2'b00, alu_res_s}, DDEPTH);
   assign dmem_addr_s  = dmem_idx_s[DW-1:0];

   // Next-PC: jump, taken branch, or sequential.
   always_comb begin
      if (ctrl_s.jump) begin
         pc_d = pc_j_idx_s[IW-1:0];
      end else if (ctrl_s.branch && (alu_zero_s ^ ctrl_s.br_ne)) begin
         pc_d = pc_br_idx_s[IW-1:0];
      end else begin
         pc_d = pc_inc_idx_s[IW-1:0];
      end
   end

   // Writeback destination and data; R0 writes are dropped here.
   always_comb begin
      case (ctrl_s.dst)
         DST_RD:  rf_waddr_s = rd_s;
         DST_RT:  rf_waddr_s = rt_s;
         DST_R31: rf_waddr_s = 5'd31;
         default: rf_waddr_s = rd_s;
      endcase
      case (ctrl_s.wsel)
         WSEL_ALU:  rf_wdata_s = alu_res_s;
         WSEL_MEM:  rf_wdata_s = data_memory[dmem_addr_s];
         WSEL_LINK: rf_wdata_s = pc_inc_idx_s;
         default:   rf_wdata_s = alu_res_s;
      endcase
      rf_we_s = ctrl_s.reg_we && (rf_waddr_s != 5'd0);
   end

   assign unused_ok_s = ^{instruction[10:6], pc_inc_idx_s, pc_br_idx_s, pc_j_idx_s, dmem_idx_s};

   // PC and register file; both cleared asynchronously while reset is low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= '0;
         for (int k = 0; k < 32; k++) begin
            register_file[k] <= 32'd0;
         end
      end else begin
         pc <= pc_d;
         if (rf_we_s) begin
            register_file[rf_waddr_s] <= rf_wdata_s;
         end
      end
   end

   // Data memory store, suppressed while reset is held.
   always_ff @(posedge clk) begin
      if (reset && ctrl_s.mem_we) begin
         data_memory[dmem_addr_s] <= rt_val_s;
      end
   end

endmodule

// File: tb/tb_iitk_mini_mips.sv
// Directed self-checking bench for iitk_mini_mips: programs are preloaded hierarchically.
module tb_iitk_mini_mips;
   import iitk_mips_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   iitk_mini_mips #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
      .clk   (clk),
      .reset (reset)
   );

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   // Hold reset and clear program memory; caller then loads words and releases.
   task automatic start_prog();
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.instruction_memory[i] <= 32'd0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #1;
      checks++; if (dut.pc !== 8'd0) begin fails++; $display("FAIL reset_pc got %0d exp 0", dut.pc); end
      checks++; if (dut.register_file[31] !== 32'd0) begin fails++; $display("FAIL reset_r31 got %h exp 0", dut.register_file[31]); end
   endtask

   task automatic test_add();
      start_prog();
      dut.instruction_memory[0] <= enc_r(5'd1, 5'd2, 5'd3, F_ADD);
      reset = 1'b1;
      dut.register_file[1] <= 32'd5;
      dut.register_file[2] <= 32'd7;
      #1;
      checks++; if ({dut.R, dut.alu, dut.I} !== 3'b110) begin fails++; $display("FAIL add_flags got %b exp 110", {dut.R, dut.alu, dut.I}); end
      step(1);
      checks++; if (dut.register_file[3] !== 32'd12) begin fails++; $display("FAIL add_r3 got %0d exp 12", dut.register_file[3]); end
      checks++; if (dut.pc !== 8'd1) begin fails++; $display("FAIL add_pc got %0d exp 1", dut.pc); end
   endtask

   task automatic test_rtype();
      start_prog();
      dut.instruction_memory[0] <= enc_r(5'd1, 5'd2, 5'd4, F_SUB);
      dut.instruction_memory[1] <= enc_r(5'd4, 5'd1, 5'd6, F_SLT);
      dut.instruction_memory[2] <= enc_r(5'd1, 5'd2, 5'd7, F_XOR);
      dut.instruction_memory[3] <= enc_r(5'd1, 5'd2, 5'd8, F_AND);
      dut.instruction_memory[4] <= enc_r(5'd1, 5'd2, 5'd9, F_OR);
      dut.instruction_memory[5] <= enc_r(5'd1, 5'd2, 5'd1, 6'h3F);
      reset = 1'b1;
      dut.register_file[1] <= 32'd5;
      dut.register_file[2] <= 32'd7;
      step(5);
      checks++; if ({dut.R, dut.alu} !== 2'b10) begin fails++; $display("FAIL badfunct_flags got %b exp 10", {dut.R, dut.alu}); end
      step(1);
      checks++; if (dut.register_file[4] !== 32'hFFFF_FFFE) begin fails++; $display("FAIL sub_r4 got %h exp fffffffe", dut.register_file[4]); end
      checks++; if (dut.register_file[6] !== 32'd1) begin fails++; $display("FAIL slt_r6 got %h exp 1", dut.register_file[6]); end
      checks++; if (dut.register_file[7] !== 32'd2) begin fails++; $display("FAIL xor_r7 got %h exp 2", dut.register_file[7]); end
      checks++; if (dut.register_file[8] !== 32'd5) begin fails++; $display("FAIL and_r8 got %h exp 5", dut.register_file[8]); end
      checks++; if (dut.register_file[9] !== 32'd7) begin fails++; $display("FAIL or_r9 got %h exp 7", dut.register_file[9]); end
      checks++; if (dut.register_file[1] !== 32'd5) begin fails++; $display("FAIL badfunct_r1 got %h exp 5", dut.register_file[1]); end
      checks++; if (dut.pc !== 8'd6) begin fails++; $display("FAIL rtype_pc got %0d exp 6", dut.pc); end
   endtask

   task automatic test_itype();
      start_prog();
      dut.instruction_memory[0] <= enc_i(OP_SLA,  5'd2, 5'd2, 16'd2);
      dut.instruction_memory[1] <= enc_i(OP_SRA,  5'd3, 5'd4, 16'd4);
      dut.instruction_memory[2] <= enc_i(OP_ADDI, 5'd0, 5'd6, 16'hFFFF);
      dut.instruction_memory[3] <= enc_i(OP_ORI,  5'd0, 5'd7, 16'hFFFF);
      dut.instruction_memory[4] <= enc_i(OP_ANDI, 5'd6, 5'd8, 16'h00F0);
      reset = 1'b1;
      dut.register_file[2] <= 32'd7;
      dut.register_file[3] <= 32'h8000_0000;
      #1;
      checks++; if ({dut.I, dut.alu, dut.R} !== 3'b110) begin fails++; $display("FAIL sla_flags got %b exp 110", {dut.I, dut.alu, dut.R}); end
      step(1);
      checks++; if (dut.register_file[2] !== 32'd28) begin fails++; $display("FAIL sla_r2 got %0d exp 28", dut.register_file[2]); end
      step(4);
      checks++; if (dut.register_file[4] !== 32'hF800_0000) begin fails++; $display("FAIL sra_r4 got %h exp f8000000", dut.register_file[4]); end
      checks++; if (dut.register_file[6] !== 32'hFFFF_FFFF) begin fails++; $display("FAIL addi_r6 got %h exp ffffffff", dut.register_file[6]); end
      checks++; if (dut.register_file[7] !== 32'h0000_FFFF) begin fails++; $display("FAIL ori_r7 got %h exp 0000ffff", dut.register_file[7]); end
      checks++; if (dut.register_file[8] !== 32'h0000_00F0) begin fails++; $display("FAIL andi_r8 got %h exp 000000f0", dut.register_file[8]); end
   endtask

   task automatic test_jump_loop();
      start_prog();
      dut.instruction_memory[2] <= enc_j(OP_J, 26'd2);
      reset = 1'b1;
      dut.register_file[1] <= 32'd9;
      step(2);
      checks++; if (dut.pc !== 8'd2) begin fails++; $display("FAIL jump_reach_pc got %0d exp 2", dut.pc); end
      checks++; if ({dut.J, dut.jump, dut.alu} !== 3'b110) begin fails++; $display("FAIL jump_flags got %b exp 110", {dut.J, dut.jump, dut.alu}); end
      for (int k = 0; k < 3; k++) begin
         step(1);
         checks++; if (dut.pc !== 8'd2) begin fails++; $display("FAIL jump_loop_pc got %0d exp 2 iter %0d", dut.pc, k); end
      end
      checks++; if (dut.register_file[1] !== 32'd9) begin fails++; $display("FAIL jump_r1 got %0d exp 9", dut.register_file[1]); end
   endtask

   task automatic test_memory();
      start_prog();
      dut.instruction_memory[0] <= enc_i(OP_SW, 5'd1, 5'd2, 16'd4);
      dut.instruction_memory[1] <= enc_i(OP_LW, 5'd1, 5'd5, 16'd4);
      reset = 1'b1;
      dut.register_file[1] <= 32'd4;
      dut.register_file[2] <= 32'h0000_DEAD;
      dut.data_memory[8]   <= 32'd0;
      #1;
      checks++; if ({dut.mem, dut.I, dut.alu} !== 3'b110) begin fails++; $display("FAIL sw_flags got %b exp 110", {dut.mem, dut.I, dut.alu}); end
      step(1);
      checks++; if (dut.data_memory[8] !== 32'h0000_DEAD) begin fails++; $display("FAIL sw_dmem8 got %h exp 0000dead", dut.data_memory[8]); end
      checks++; if (dut.mem !== 1'b1) begin fails++; $display("FAIL lw_flag got %b exp 1", dut.mem); end
      step(1);
      checks++; if (dut.register_file[5] !== 32'h0000_DEAD) begin fails++; $display("FAIL lw_r5 got %h exp 0000dead", dut.register_file[5]); end
   endtask

   task automatic test_branch();
      start_prog();
      dut.instruction_memory[0] <= enc_i(OP_BEQ, 5'd1, 5'd1, 16'd3);
      dut.instruction_memory[4] <= enc_i(OP_BNE, 5'd1, 5'd1, 16'd3);
      dut.instruction_memory[5] <= enc_i(OP_BNE, 5'd1, 5'd0, 16'hFFFF);
      reset = 1'b1;
      dut.register_file[1] <= 32'd5;
      #1;
      checks++; if ({dut.branch, dut.I} !== 2'b11) begin fails++; $display("FAIL beq_flags got %b exp 11", {dut.branch, dut.I}); end
      step(1);
      checks++; if (dut.pc !== 8'd4) begin fails++; $display("FAIL beq_taken_pc got %0d exp 4", dut.pc); end
      step(1);
      checks++; if (dut.pc !== 8'd5) begin fails++; $display("FAIL bne_not_taken_pc got %0d exp 5", dut.pc); end
      step(1);
      checks++; if (dut.pc !== 8'd5) begin fails++; $display("FAIL bne_back_pc got %0d exp 5", dut.pc); end
   endtask

   task automatic test_undefined();
      start_prog();
      dut.instruction_memory[0] <= enc_i(6'b111111, 5'd1, 5'd1, 16'd5);
      dut.instruction_memory[1] <= enc_j(OP_JAL, 26'd7);
      reset = 1'b1;
      dut.register_file[1] <= 32'd3;
      #1;
      checks++; if ({dut.alu, dut.mem, dut.branch, dut.jump, dut.R, dut.I, dut.J} !== 7'd0) begin
         fails++; $display("FAIL undef_flags got %b exp 0000000", {dut.alu, dut.mem, dut.branch, dut.jump, dut.R, dut.I, dut.J}); end
      step(1);
      checks++; if (dut.pc !== 8'd1) begin fails++; $display("FAIL undef_pc got %0d exp 1", dut.pc); end
      checks++; if (dut.register_file[1] !== 32'd3) begin fails++; $display("FAIL undef_r1 got %0d exp 3", dut.register_file[1]); end
`ifdef IITK_MIPS_JAL_EN
      checks++; if ({dut.J, dut.jump} !== 2'b11) begin fails++; $display("FAIL jal_flags got %b exp 11", {dut.J, dut.jump}); end
      step(1);
      checks++; if (dut.pc !== 8'd7) begin fails++; $display("FAIL jal_pc got %0d exp 7", dut.pc); end
      checks++; if (dut.register_file[31] !== 32'd2) begin fails++; $display("FAIL jal_r31 got %0d exp 2", dut.register_file[31]); end
`else
      checks++; if ({dut.J, dut.jump} !== 2'b00) begin fails++; $display("FAIL jal_nop_flags got %b exp 00", {dut.J, dut.jump}); end
      step(1);
      checks++; if (dut.pc !== 8'd2) begin fails++; $display("FAIL jal_nop_pc got %0d exp 2", dut.pc); end
      checks++; if (dut.register_file[31] !== 32'd0) begin fails++; $display("FAIL jal_nop_r31 got %0d exp 0", dut.register_file[31]); end
`endif
   endtask

   task automatic test_r0_write();
      start_prog();
      dut.instruction_memory[0] <= enc_i(OP_ADDI, 5'd1, 5'd0, 16'd5);
      dut.instruction_memory[1] <= enc_r(5'd0, 5'd1, 5'd2, F_ADD);
      reset = 1'b1;
      dut.register_file[1] <= 32'd9;
      step(1);
      checks++; if (dut.register_file[0] !== 32'd0) begin fails++; $display("FAIL r0_write got %0d exp 0", dut.register_file[0]); end
      step(1);
      checks++; if (dut.register_file[2] !== 32'd9) begin fails++; $display("FAIL r0_read got %0d exp 9", dut.register_file[2]); end
   endtask

   task automatic test_reset_mid_run();
      start_prog();
      dut.instruction_memory[0] <= enc_i(OP_SW,   5'd0, 5'd1, 16'd20);
      dut.instruction_memory[1] <= enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7);
      dut.instruction_memory[2] <= enc_i(OP_ADDI, 5'd0, 5'd2, 16'd3);
      reset = 1'b1;
      dut.register_file[1] <= 32'h55;
      dut.data_memory[20]  <= 32'd0;
      step(1);
      checks++; if (dut.data_memory[20] !== 32'h55) begin fails++; $display("FAIL mid_sw got %h exp 55", dut.data_memory[20]); end
      step(2);
      checks++; if (dut.pc !== 8'd3) begin fails++; $display("FAIL mid_pc_before got %0d exp 3", dut.pc); end
      reset = 1'b0;
      #1;
      checks++; if (dut.pc !== 8'd0) begin fails++; $display("FAIL mid_async_pc got %0d exp 0", dut.pc); end
      checks++; if ({dut.register_file[1], dut.register_file[2]} !== 64'd0) begin
         fails++; $display("FAIL mid_async_regs got %h %h exp 0 0", dut.register_file[1], dut.register_file[2]); end
      step(1);
      checks++; if (dut.data_memory[20] !== 32'h55) begin fails++; $display("FAIL mid_store_suppressed got %h exp 55", dut.data_memory[20]); end
      @(negedge clk);
      reset = 1'b1;
      step(1);
      checks++; if (dut.pc !== 8'd1) begin fails++; $display("FAIL mid_restart_pc got %0d exp 1", dut.pc); end
      checks++; if (dut.data_memory[20] !== 32'd0) begin fails++; $display("FAIL mid_restart_sw got %h exp 0", dut.data_memory[20]); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_rtype();
      test_itype();
      test_jump_loop();
      test_memory();
      test_branch();
      test_undefined();
      test_r0_write();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
